uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
Buffered transmit front-end between the SoC's memory-mapped UART window (addr_high 4'h2) and the uart transmitter. Bus-side byte writes are pushed into a FIFO and complete in one cycle. A drain FSM feeds bytes to uart over its sendData/sendReq/ready handshake. Status is exported for the bus read path, so firmware polls the level instead of tx_ready.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
DEPTH_BITS, $clog2(DEPTH), pointer width; level counter is DEPTH_BITS+1 bits

Ports:
clk  input  1  system clock; all state on posedge
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  bus write strobe for one byte, single-cycle pulse
wr_data  input  8  byte to transmit
wr_ready  output  1  high when a push this cycle is accepted (not full)
ovf_clr  input  1  clears the sticky overflow flag
tx_data  output  8  to uart sendData
tx_send  output  1  to uart sendReq, single-cycle pulse
tx_ready  input  1  from uart ready; high when uart is idle
level  output  DEPTH_BITS+1  current FIFO occupancy
empty  output  1  level == 0
full  output  1  level == DEPTH
overflow  output  1  sticky; set when wr_valid arrives while full
busy  output  1  FIFO not empty or FSM not IDLE; used as the drain-complete test

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, empty=1, full=0, overflow=0, wr_ready=1, tx_send=0, tx_data=8'h00, FSM=IDLE, busy=0.
- Push: wr_valid && !full writes mem[wr_ptr], wr_ptr++ (wraps modulo DEPTH). wr_valid && full drops the byte and sets overflow.
- ovf_clr clears overflow. If set and clear happen in the same cycle, set wins.
- wr_ready = !full, combinational from registered level.
- Pop and push in the same cycle: level unchanged, both pointers advance. This holds when full: the pop frees a slot in the same cycle, so the push is accepted. When empty, a push is never popped in the same cycle, because the pop reads registered state.
- Drain FSM:
  - IDLE: if !empty && tx_ready, load tx_data=mem[rd_ptr], pulse tx_send, pop (rd_ptr++), go to ACK.
  - ACK: wait for tx_ready==0, meaning uart has latched the byte, then go to DRAIN.
  - DRAIN: wait for tx_ready==1, then go to IDLE.
  - Back-to-back minimum per byte: send cycle + uart frame + 1 IDLE cycle.
- tx_send is high for exactly one cycle per popped byte. tx_data is held stable until the next send.
- Reset mid-frame: buffered bytes are discarded and the FSM returns to IDLE. The uart frame in flight is uart's concern.
- level is always pushes minus pops, saturating logic not permitted; overflow is the only loss path.

Optional Feature:
UART_TXBUF_CRLF_EN
- Defined: when the byte popped in IDLE is 8'h0A, the FSM first sends 8'h0D and then 8'h0A without a second pop. This uses an extra state CR_PEND, entered after DRAIN in place of IDLE, with the 8'h0A held in a register. The 8'h0A is then sent through the normal ACK/DRAIN sequence before returning to IDLE.
- Undefined: bytes are sent verbatim and CR_PEND does not exist.

Decomposition:
- Package uart_txbuf_pkg holds:
  - the FSM state enum: IDLE, ACK, DRAIN, CR_PEND;
  - the constants ASCII_LF=8'h0A and ASCII_CR=8'h0D;
  - the status word packing used by the SoC read mux: {overflow, full, empty, level} in the low bits, zero-extended to 32.
- One sub-module is natural: sync_fifo, a parameterised storage, pointer and level block exposing push/pop/full/empty/level. uart_tx_buffer instantiates it and adds the FSM and overflow logic.

Test Plan:
- Reset with wr_valid held high, then release: level=0, empty=1, tx_send never pulses during reset.
- Push 'H','i' with the uart model idle: tx_send pulses twice, tx_data = 8'h48 then 8'h69, level returns to 0, busy drops after the second frame.
- Push 17 bytes with DEPTH=16 and tx_ready held 0: level=16, full=1, wr_ready=0, overflow=1, byte 17 is never sent. ovf_clr then gives overflow=0.
- Full FIFO, release tx_ready and push in the same cycle as the first pop: level stays 16, all 16 bytes drain in order.
- Pointer wrap: 40 bytes pushed in 3 bursts with interleaved draining: output order exactly matches input, no duplicates.
- With UART_TXBUF_CRLF_EN, push 'A', 8'h0A: sent sequence is 8'h41, 8'h0D, 8'h0A, and level decrements by 2 total. Without the macro, the sequence is 8'h41, 8'h0A.

Source files
------------

// File: rtl/uart_txbuf_pkg.sv
// Shared types and constants for the buffered UART transmit front-end:
// drain FSM states, ASCII line-ending bytes and the status word packing.
package uart_txbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    DRAIN   = 2'd2,
    CR_PEND = 2'd3
  } txbuf_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int STATUS_LEVEL_W = 16;

  // Status word for the SoC read mux: {overflow, full, empty, level}, zero-extended.
  function automatic logic [31:0] status_word(input logic                      ovf,
                                              input logic                      is_full,
                                              input logic                      is_empty,
                                              input logic [STATUS_LEVEL_W-1:0] lvl);
    return {13'd0, ovf, is_full, is_empty, lvl};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parameterised byte FIFO: storage array, read/write pointers and an occupancy
// counter. Callers must only push when there is room and only pop when non-empty.
module sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          rd_data,
  output logic [DEPTH_BITS:0] level,
  output logic                empty,
  output logic                full
);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_BITS-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_BITS:0]   level_reg, level_next;

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (pop && !push) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;
  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (DEPTH_BITS+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmit front-end: bus writes land in a FIFO, a drain FSM hands
// bytes to the uart. Define UART_TXBUF_CRLF_EN to expand LF into CR,LF on the wire.
module uart_tx_buffer
  import uart_txbuf_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [7:0]          wr_data,
  output logic                wr_ready,
  input  logic                ovf_clr,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_ready,
  output logic [DEPTH_BITS:0] level,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                busy
);

  txbuf_state_t state_reg, state_next;
  logic [7:0]   tx_data_reg, tx_data_next;
  logic         tx_send_reg, tx_send_next;
  logic         overflow_reg, overflow_next;
  logic         pop;
  logic         push;
  logic [7:0]   rd_data;
`ifdef UART_TXBUF_CRLF_EN
  logic         lf_pend_reg, lf_pend_next;
`endif

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push = wr_valid && (!full || pop);

  always_comb begin
    overflow_next = overflow_reg;
    if (ovf_clr) begin
      overflow_next = 1'b0;
    end
    if (wr_valid && full && !pop) begin
      overflow_next = 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data_reg;
    tx_send_next = 1'b0;
    pop          = 1'b0;
`ifdef UART_TXBUF_CRLF_EN
    lf_pend_next = lf_pend_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop          = 1'b1;
          tx_send_next = 1'b1;
          tx_data_next = rd_data;
          state_next   = ACK;
`ifdef UART_TXBUF_CRLF_EN
          if (rd_data == ASCII_LF) begin
            tx_data_next = ASCII_CR;
            lf_pend_next = 1'b1;
          end
`endif
        end
      end
      ACK: begin
        if (!tx_ready) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (tx_ready) begin
`ifdef UART_TXBUF_CRLF_EN
          state_next = lf_pend_reg ? CR_PEND : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      CR_PEND: begin
`ifdef UART_TXBUF_CRLF_EN
        // The LF was already popped; send it without touching the FIFO.
        if (tx_ready) begin
          tx_data_next = ASCII_LF;
          tx_send_next = 1'b1;
          lf_pend_next = 1'b0;
          state_next   = ACK;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_data_reg  <= 8'h00;
      tx_send_reg  <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef UART_TXBUF_CRLF_EN
      lf_pend_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tx_data_reg  <= tx_data_next;
      tx_send_reg  <= tx_send_next;
      overflow_reg <= overflow_next;
`ifdef UART_TXBUF_CRLF_EN
      lf_pend_reg  <= lf_pend_next;
`endif
    end
  end

  assign wr_ready = !full;
  assign tx_data  = tx_data_reg;
  assign tx_send  = tx_send_reg;
  assign overflow = overflow_reg;
  assign busy     = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple uart model that drops ready
// for a fixed frame time after each sendReq. Honours UART_TXBUF_CRLF_EN.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int DB    = $clog2(DEPTH);
  localparam int FRAME = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          ovf_clr;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic [DB:0]   level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          busy;

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic          hold;
  int            cnt;
  logic [7:0]    sent [$];
  logic [7:0]    expq [$];

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_ready (tx_ready),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .busy     (busy)
  );

  // uart model: latches the byte on sendReq, busy for FRAME cycles
  assign tx_ready = !hold && (cnt == 0);

  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
    end else if (tx_send) begin
      sent.push_back(tx_data);
      $display("[TB] uart got byte %02h", tx_data);
      cnt = FRAME;
    end else if (cnt != 0) begin
      cnt = cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy && tx_ready) done = 1'b1;
    end
    check({tag, "_drain_done"}, done, 1);
  endtask

  task automatic wait_level_le(input int lim);
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (level <= lim) done = 1'b0 | 1'b1;
    end
    check("level_wait_done", done, 1);
  endtask

  task automatic compare_sent(input string tag);
    check({tag, "_count"}, sent.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < sent.size()) ? sent[i] : 8'hxx, expq[i]);
    end
    sent.delete();
    expq.delete();
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    ovf_clr  = 1'b0;
    hold     = 1'b0;
    cnt      = 0;

    // Reset with wr_valid held high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_tx_send", tx_send, 0);
    end
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_no_bytes", sent.size(), 0);
    $display("[TB] reset checks done");

    // "Hi" with an idle uart
    push(8'h48);
    push(8'h69);
    wait_drain("hi");
    check("hi_level", level, 0);
    check("hi_busy", busy, 0);
    expq = '{8'h48, 8'h69};
    compare_sent("hi");

    // Fill with uart stalled; 17th byte is dropped
    hold = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    check("fill_level", level, 16);
    check("fill_full", full, 1);
    check("fill_wr_ready", wr_ready, 0);
    check("fill_overflow", overflow, 1);
    check("fill_no_send", sent.size(), 0);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    $display("[TB] fill/overflow checks done");

    // Push into full FIFO in the same cycle as the first pop
    hold = 1'b0;
    push(8'h30);
    check("popush_level", level, 16);
    check("popush_full", full, 1);
    check("popush_overflow", overflow, 0);
    wait_drain("popush");
    for (int i = 0; i < 16; i++) expq.push_back(8'h10 + 8'(i));
    expq.push_back(8'h30);
    compare_sent("popush");

    // Pointer wrap: 40 bytes in 3 bursts with draining in between
    for (int i = 0; i < 14; i++) push(8'h40 + 8'(i));
    wait_level_le(3);
    for (int i = 14; i < 27; i++) push(8'h40 + 8'(i));
    wait_level_le(3);
    for (int i = 27; i < 40; i++) push(8'h40 + 8'(i));
    wait_drain("wrap");
    check("wrap_overflow", overflow, 0);
    for (int i = 0; i < 40; i++) expq.push_back(8'h40 + 8'(i));
    compare_sent("wrap");

    // Line feed handling
    push(8'h41);
    push(8'h0A);
    wait_drain("lf");
    check("lf_level", level, 0);
`ifdef UART_TXBUF_CRLF_EN
    expq = '{8'h41, 8'h0D, 8'h0A};
`else
    expq = '{8'h41, 8'h0A};
`endif
    compare_sent("lf");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
